sprite_position_scheduler: RTL

Central position controller for up to NUM_SPRITES movable sprites. It accepts move commands from game logic through a valid/ready port and applies each step to per-sprite shadow registers, clamping every position to the screen. At the start of each vertical blank it commits the shadow positions to the per-sprite outputs feeding the sprite printers, so a sprite never tears mid-frame. It sits between the input/speed FSMs and the printSprite instances.

---
 rtl/sprite_pkg.sv | 32 +++
 rtl/sprite_step_clamp.sv | 55 +++++
 rtl/sprite_position_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite position path: move direction codes,
// commit FSM states, default screen geometry and a saturating clamp helper.
package sprite_pkg;

  localparam logic [2:0] DIR_LEFT  = 3'b001;
  localparam logic [2:0] DIR_RIGHT = 3'b010;
  localparam logic [2:0] DIR_UP    = 3'b011;
  localparam logic [2:0] DIR_DOWN  = 3'b100;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  // Saturate a signed coordinate into [0, hi]; negative values never wrap.
  function automatic logic signed [11:0] clamp12(input logic signed [11:0] v,
                                                 input logic signed [11:0] hi);
    logic signed [11:0] r;
    if (v < 12'sd0) begin
      r = 12'sd0;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_step_clamp.sv
// Combinational single-step mover: applies one direction/step to an x/y pair
// and clamps the result so the whole sprite stays on screen.
module sprite_step_clamp
  import sprite_pkg::*;
#(
  parameter int STEP_W      = 3,
  parameter int SCREEN_W    = sprite_pkg::SCREEN_W,
  parameter int SCREEN_H    = sprite_pkg::SCREEN_H,
  parameter int SPRITE_SIZE = 25
) (
  input  logic [10:0]       x,
  input  logic [9:0]        y,
  input  logic [2:0]        dir,
  input  logic [STEP_W-1:0] step,
  output logic [10:0]       next_x,
  output logic [9:0]        next_y
);

  localparam logic signed [11:0] MAX_X = 12'(SCREEN_W - SPRITE_SIZE);
  localparam logic signed [11:0] MAX_Y = 12'(SCREEN_H - SPRITE_SIZE);

  logic signed [11:0] x_s;
  logic signed [11:0] y_s;
  logic signed [11:0] step_s;
  logic signed [11:0] sum_x_s;
  logic signed [11:0] sum_y_s;
  logic signed [11:0] clamp_x_s;
  logic signed [11:0] clamp_y_s;

  assign x_s    = signed'({1'b0, x});
  assign y_s    = signed'({2'b00, y});
  assign step_s = signed'(12'(step));

  // Unclamped target position for the requested direction
  always_comb begin
    sum_x_s = x_s;
    sum_y_s = y_s;
    case (dir)
      DIR_LEFT:  sum_x_s = x_s - step_s;
      DIR_RIGHT: sum_x_s = x_s + step_s;
      DIR_UP:    sum_y_s = y_s - step_s;
      DIR_DOWN:  sum_y_s = y_s + step_s;
      default: begin
        sum_x_s = x_s;
        sum_y_s = y_s;
      end
    endcase
  end

  assign clamp_x_s = clamp12(sum_x_s, MAX_X);
  assign clamp_y_s = clamp12(sum_y_s, MAX_Y);
  assign next_x    = clamp_x_s[10:0];
  assign next_y    = clamp_y_s[9:0];

endmodule

// File: rtl/sprite_position_scheduler.sv
// Per-sprite shadow positions updated by move commands, committed to the
// printer-facing outputs one sprite per cycle at the start of vertical blank.
module sprite_position_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int ID_W        = 2,
  parameter int STEP_W      = 3,
  parameter int SCREEN_W    = sprite_pkg::SCREEN_W,
  parameter int SCREEN_H    = sprite_pkg::SCREEN_H,
  parameter int SPRITE_SIZE = 25,
  parameter int INIT_X      = 50,
  parameter int INIT_Y      = 300,
  parameter int SPACING_X   = 60
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ID_W-1:0]           cmd_id,
  input  logic [2:0]                cmd_dir,
  input  logic [STEP_W-1:0]         cmd_step,
  input  logic [10:0]               pixel_x,
  input  logic [9:0]                pixel_y,
  output logic [11*NUM_SPRITES-1:0] pos_x,
  output logic [10*NUM_SPRITES-1:0] pos_y,
  output logic [NUM_SPRITES-1:0]    move,
  output logic                      frame_tick
);

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_SPRITES - 1);
  localparam logic [9:0]      VB_LINE  = 10'(SCREEN_H);

  state_t                  state_r;
  state_t                  state_nx_s;
  logic [ID_W-1:0]         idx_r;
  logic [ID_W-1:0]         idx_nx_s;
  logic [10:0]             sx_r [NUM_SPRITES];
  logic [9:0]              sy_r [NUM_SPRITES];
  logic [10:0]             px_r [NUM_SPRITES];
  logic [9:0]              py_r [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]  move_r;
  logic                    frame_tick_r;
  logic                    vb_start_s;
  logic                    cmd_fire_s;
  logic [10:0]             cur_x_s;
  logic [9:0]              cur_y_s;
  logic [10:0]             next_x_s;
  logic [9:0]              next_y_s;

  assign vb_start_s = (pixel_x == 11'd0) && (pixel_y == VB_LINE);
  assign cmd_ready  = (state_r == IDLE);
  assign cmd_fire_s = cmd_valid && cmd_ready;

  // Select the addressed sprite's shadow position; out-of-range ids match nothing
  always_comb begin
    cur_x_s = sx_r[0];
    cur_y_s = sy_r[0];
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (cmd_id == ID_W'(i)) begin
        cur_x_s = sx_r[i];
        cur_y_s = sy_r[i];
      end else begin
        cur_x_s = cur_x_s;
        cur_y_s = cur_y_s;
      end
    end
  end

  sprite_step_clamp #(
    .STEP_W      (STEP_W),
    .SCREEN_W    (SCREEN_W),
    .SCREEN_H    (SCREEN_H),
    .SPRITE_SIZE (SPRITE_SIZE)
  ) u_step_clamp (
    .x      (cur_x_s),
    .y      (cur_y_s),
    .dir    (cmd_dir),
    .step   (cmd_step),
    .next_x (next_x_s),
    .next_y (next_y_s)
  );

  // Commit FSM next-state: walk idx across all sprites once per blank
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (vb_start_s) begin
          state_nx_s = COMMIT;
          idx_nx_s   = '0;
        end else begin
          state_nx_s = IDLE;
        end
      end
      COMMIT: begin
        if (idx_r == LAST_IDX) begin
          state_nx_s = IDLE;
          idx_nx_s   = '0;
        end else begin
          idx_nx_s = idx_r + ID_W'(1);
        end
      end
      default: begin
        state_nx_s = IDLE;
        idx_nx_s   = '0;
      end
    endcase
  end

  // Commit FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= '0;
    end else begin
      state_r <= state_nx_s;
      idx_r   <= idx_nx_s;
    end
  end

  // Shadow update, per-sprite commit, move strobes and frame tick
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sx_r[i] <= 11'(INIT_X + i * SPACING_X);
        sy_r[i] <= 10'(INIT_Y);
        px_r[i] <= 11'(INIT_X + i * SPACING_X);
        py_r[i] <= 10'(INIT_Y);
      end
      move_r       <= '0;
      frame_tick_r <= 1'b0;
    end else begin
      move_r       <= '0;
      frame_tick_r <= (state_r == IDLE) && vb_start_s;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (cmd_fire_s && (cmd_id == ID_W'(i))) begin
          sx_r[i] <= next_x_s;
          sy_r[i] <= next_y_s;
        end
        if ((state_r == COMMIT) && (idx_r == ID_W'(i))) begin
          px_r[i]   <= sx_r[i];
          py_r[i]   <= sy_r[i];
          move_r[i] <= (px_r[i] != sx_r[i]) || (py_r[i] != sy_r[i]);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_pack
    assign pos_x[11*g +: 11] = px_r[g];
    assign pos_y[10*g +: 10] = py_r[g];
  end

  assign move       = move_r;
  assign frame_tick = frame_tick_r;

endmodule
